// File: rtl/gpr_read_port_if.sv
// Read-request / read-response / writeback bundle for the NPC general-purpose register file.
// master = decode + writeback side, slave = register file.
interface gpr_read_port_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_rs1;
  logic [AW-1:0]    req_rs2;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata1;
  logic [WIDTH-1:0] resp_rdata2;

  modport master (
    output wen, waddr, wdata, req_valid, req_rs1, req_rs2, resp_ready,
    input  req_ready, resp_valid, resp_rdata1, resp_rdata2
  );

  modport slave (
    input  wen, waddr, wdata, req_valid, req_rs1, req_rs2, resp_ready,
    output req_ready, resp_valid, resp_rdata1, resp_rdata2
  );
endinterface

// File: rtl/gpr_read_port.sv
// Register file with a two-operand valid/ready read port and a single-entry response register.
// The held response tracks writeback: same-cycle write bypass on load, refresh while stalled.
module gpr_read_port #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  gpr_read_port_if.slave  bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [WIDTH-1:0] regs_r [1:NREG-1];

  logic [0:0]       state_r;
  logic [0:0]       state_s;
  logic [AW-1:0]    rs1_r;
  logic [AW-1:0]    rs2_r;
  logic [AW-1:0]    rs1_s;
  logic [AW-1:0]    rs2_s;
  logic [WIDTH-1:0] rdata1_r;
  logic [WIDTH-1:0] rdata2_r;
  logic [WIDTH-1:0] rdata1_s;
  logic [WIDTH-1:0] rdata2_s;
  logic [WIDTH-1:0] op1_s;
  logic [WIDTH-1:0] op2_s;

  logic resp_valid_s;
  logic req_ready_s;
  logic accept_s;
  logic deq_s;
  logic wr_s;

  assign resp_valid_s = (state_r == ST_FULL);
  assign req_ready_s  = !resp_valid_s || bus.resp_ready;
  assign accept_s     = bus.req_valid && req_ready_s;
  assign deq_s        = resp_valid_s && bus.resp_ready;
  assign wr_s         = bus.wen && (bus.waddr != {AW{1'b0}});

  assign bus.req_ready   = req_ready_s;
  assign bus.resp_valid  = resp_valid_s;
  assign bus.resp_rdata1 = rdata1_r;
  assign bus.resp_rdata2 = rdata2_r;

  // Operand 1 lookup: x0 reads zero, a same-cycle write wins over the array.
  always_comb begin
    op1_s = {WIDTH{1'b0}};
    if (bus.req_rs1 == {AW{1'b0}}) begin
      op1_s = {WIDTH{1'b0}};
    end else if (bus.wen && (bus.waddr == bus.req_rs1)) begin
      op1_s = bus.wdata;
    end else begin
      op1_s = regs_r[bus.req_rs1];
    end
  end

  // Operand 2 lookup, same rules as operand 1.
  always_comb begin
    op2_s = {WIDTH{1'b0}};
    if (bus.req_rs2 == {AW{1'b0}}) begin
      op2_s = {WIDTH{1'b0}};
    end else if (bus.wen && (bus.waddr == bus.req_rs2)) begin
      op2_s = bus.wdata;
    end else begin
      op2_s = regs_r[bus.req_rs2];
    end
  end

  // Response FSM next state: accept always fills, dequeue without accept drains.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_s = ST_FULL;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_s = ST_FULL;
        end else if (deq_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Response payload next value: load on accept, refresh only while stalled.
  always_comb begin
    rs1_s    = rs1_r;
    rs2_s    = rs2_r;
    rdata1_s = rdata1_r;
    rdata2_s = rdata2_r;
    if (accept_s) begin
      rs1_s    = bus.req_rs1;
      rs2_s    = bus.req_rs2;
      rdata1_s = op1_s;
      rdata2_s = op2_s;
    end else if (resp_valid_s && !deq_s) begin
      // Both operands may refresh from the same write when rs1_q == rs2_q.
      if (wr_s && (bus.waddr == rs1_r)) begin
        rdata1_s = bus.wdata;
      end else begin
        rdata1_s = rdata1_r;
      end
      if (wr_s && (bus.waddr == rs2_r)) begin
        rdata2_s = bus.wdata;
      end else begin
        rdata2_s = rdata2_r;
      end
    end else begin
      rdata1_s = rdata1_r;
      rdata2_s = rdata2_r;
    end
  end

  // Response register and FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_EMPTY;
      rs1_r    <= {AW{1'b0}};
      rs2_r    <= {AW{1'b0}};
      rdata1_r <= {WIDTH{1'b0}};
      rdata2_r <= {WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      rs1_r    <= rs1_s;
      rs2_r    <= rs2_s;
      rdata1_r <= rdata1_s;
      rdata2_r <= rdata2_s;
    end
  end

  // Architectural registers 1..NREG-1; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_s) begin
      regs_r[bus.waddr] <= bus.wdata;
    end
  end

endmodule

// File: tb/tb_gpr_read_port.sv
// Directed self-checking bench for gpr_read_port: vector table plus streaming and async-reset sequences.
module tb_gpr_read_port;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  gpr_read_port_if #(.WIDTH(32), .AW(5)) bus ();

  gpr_read_port #(.WIDTH(32), .NREG(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rr;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic rv, input logic [4:0] rs1, input logic [4:0] rs2, input logic rr);
    bus.wen        = wen;
    bus.waddr      = waddr;
    bus.wdata      = wdata;
    bus.req_valid  = rv;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.resp_ready = rr;
  endtask

  // Drive at negedge, check req_ready before the edge, check the response after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.wen, v.waddr, v.wdata, v.rv, v.rs1, v.rs2, v.rr);
    #1;
    chk($sformatf("v%0d_req_ready", idx), {31'd0, bus.req_ready}, {31'd0, v.exp_ready});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_resp_valid", idx), {31'd0, bus.resp_valid}, {31'd0, v.exp_valid});
    chk($sformatf("v%0d_rdata1", idx), bus.resp_rdata1, v.exp_d1);
    chk($sformatf("v%0d_rdata2", idx), bus.resp_rdata2, v.exp_d2);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    //           wen   waddr  wdata          rv    rs1    rs2    rr    rdy   vld   d1             d2
    vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd5,  1'b0, 1'b1, 1'b1, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  5'd5,  1'b0, 1'b1, 1'b1, 32'hDEADBEEF,  32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd0,  32'h1234,      1'b1, 5'd0,  5'd5,  1'b1, 1'b1, 1'b1, 32'h0,         32'hDEADBEEF};
    vecs[4]  = '{1'b1, 5'd7,  32'h11,        1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
    vecs[5]  = '{1'b1, 5'd3,  32'h33,        1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
    vecs[6]  = '{1'b1, 5'd7,  32'h22,        1'b1, 5'd7,  5'd3,  1'b0, 1'b1, 1'b1, 32'h22,        32'h33};
    vecs[7]  = '{1'b1, 5'd4,  32'hA,         1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 32'h22,        32'h33};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 32'hA,         32'h33};
    vecs[9]  = '{1'b1, 5'd4,  32'hB,         1'b1, 5'd1,  5'd1,  1'b0, 1'b0, 1'b1, 32'hB,         32'h33};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  5'd1,  1'b0, 1'b0, 1'b1, 32'hB,         32'h33};
    vecs[11] = '{1'b1, 5'd3,  32'h44,        1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hB,         32'h44};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  5'd4,  1'b1, 1'b1, 1'b1, 32'hB,         32'hB};
    vecs[13] = '{1'b1, 5'd4,  32'hC,         1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hC,         32'hC};
    vecs[14] = '{1'b1, 5'd4,  32'hD,         1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 32'hC,         32'hC};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 32'hD,         32'h44};

    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("reset_rdata1", bus.resp_rdata1, 32'h0);
    chk("reset_rdata2", bus.resp_rdata2, 32'h0);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i], i);
    end

    // Streaming: preload x1..x8, then eight back-to-back reads with resp_ready held high.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive(1'b1, i[4:0], i * 32'h10, 1'b0, 5'd0, 5'd0, 1'b1);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b1, i[4:0], 5'd0, 1'b1);
      #1;
      chk($sformatf("stream%0d_req_ready", i), {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_resp_valid", i), {31'd0, bus.resp_valid}, 32'd1);
      chk($sformatf("stream%0d_rdata1", i), bus.resp_rdata1, i * 32'h10);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("stream_drain_valid", {31'd0, bus.resp_valid}, 32'd0);

    // Async reset while a response is stalled.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b0);
    @(posedge clk);
    #1;
    chk("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("stall_rdata1", bus.resp_rdata1, 32'h55);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("arst_rdata1", bus.resp_rdata1, 32'h0);
    chk("arst_rdata2", bus.resp_rdata2, 32'h0);
    chk("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("post_rst_x9", bus.resp_rdata1, 32'h0);
    chk("post_rst_x5", bus.resp_rdata2, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
